message_sender: RTL and testbench

- Read-side sequencer for the bit-reversal message RAM.
- On a start pulse it walks addresses 0..MSG_LEN-1 of the message RAM and captures each returned character after the RAM's registered read latency.
- It hands each character to the UART transmitter using a one-cycle new_tx_data strobe, gated by tx_busy.
- It sits between the message RAM (addr/data port) and the serial transmitter, and replaces ad-hoc printing logic.

---
 rtl/message_sender.sv | 98 +++++++++
 tb/tb_message_sender.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_sender.sv
// rtl/message_sender.sv - read-side sequencer that streams message RAM characters to a UART transmitter
// Walks RAM addresses 0..MSG_LEN-1, waits RD_LAT cycles per read, and strobes each character out.
module message_sender #(
    parameter int MSG_LEN = 10,
    parameter int ADDR_W  = 4,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data,
    output logic [7:0]        tx_data,
    output logic              new_tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
    localparam logic [1:0]        LAT_LOAD  = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SEND,
        S_GAP
    } state_t;

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_tx_data;
    logic              r_new_tx_data;
    logic              r_busy;
    logic              r_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 2'd0;
            r_addr        <= '0;
            r_tx_data     <= 8'h00;
            r_new_tx_data <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_new_tx_data <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_addr <= '0;
                    // The done cycle still belongs to the finished message, so a start there is dropped.
                    if (start && !r_done) begin
                        r_state <= S_WAIT;
                        r_cnt   <= LAT_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_tx_data <= data;
                        r_state   <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        r_new_tx_data <= 1'b1;
                        r_state       <= S_GAP;
                    end
                end
                S_GAP: begin
                    // tx_busy is not looked at here: the transmitter raises it one cycle late.
                    if (r_addr == LAST_ADDR) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_addr  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_cnt   <= LAT_LOAD;
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign addr        = r_addr;
    assign tx_data     = r_tx_data;
    assign new_tx_data = r_new_tx_data;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_message_sender.sv
// tb/tb_message_sender.sv - self-checking bench for message_sender with RAM and transmitter models
module tb_message_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, start1, start2;
    logic       tx_busy0;
    logic [3:0] addr0, addr1, addr2;
    logic [7:0] data0, data1, data2;
    logic [7:0] txd0, txd1, txd2;
    logic       new0, new1, new2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    logic [7:0] mem2 [16];
    logic [3:0] p1a, p1b, p2a;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // RAM models: RD_LAT-1 address register stages in front of an asynchronous read.
    assign data0 = mem0[addr0];
    always @(posedge clk) begin
        p1a <= addr1;
        p1b <= p1a;
        p2a <= addr2;
    end
    assign data1 = mem1[p1b];
    assign data2 = mem2[p2a];

    always @(posedge clk) cyc <= cyc + 1;

    message_sender #(.MSG_LEN(10), .ADDR_W(4), .RD_LAT(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .addr(addr0), .data(data0),
        .tx_data(txd0), .new_tx_data(new0), .tx_busy(tx_busy0), .busy(busy0), .done(done0)
    );
    message_sender #(.MSG_LEN(1), .ADDR_W(4), .RD_LAT(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .addr(addr1), .data(data1),
        .tx_data(txd1), .new_tx_data(new1), .tx_busy(1'b0), .busy(busy1), .done(done1)
    );
    message_sender #(.MSG_LEN(16), .ADDR_W(4), .RD_LAT(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .addr(addr2), .data(data2),
        .tx_data(txd2), .new_tx_data(new2), .tx_busy(1'b0), .busy(busy2), .done(done2)
    );

    // Strobe/done recorder for the main instance.
    logic [7:0] sq [$];
    int         st [$];
    int         dt [$];
    int         dbl = 0;
    logic       prev_new = 1'b0;
    always @(negedge clk) begin
        if (new0) begin
            sq.push_back(txd0);
            st.push_back(cyc);
            if (prev_new) dbl <= dbl + 1;
        end
        if (done0) dt.push_back(cyc);
        prev_new <= new0;
    end

    task automatic pulse0(output int t0);
        @(negedge clk);
        start0 = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic load_basic();
        logic [7:0] s [10];
        s = '{8'h31, 8'h30, 8'h31, 8'h31, 8'h30, 8'h30, 8'h31, 8'h30, 8'h0A, 8'h0D};
        for (int i = 0; i < 16; i++) mem0[i] = (i < 10) ? s[i] : 8'hEE;
    endtask

    task automatic load_random0();
        for (int i = 0; i < 16; i++) mem0[i] = 8'hEE;
        for (int i = 0; i < 8; i++) mem0[i] = 8'h30 + 8'($urandom_range(0, 1));
        mem0[8] = 8'h0A;
        mem0[9] = 8'h0D;
    endtask

    task automatic test_basic();
        int t0, b, bd, d0;
        load_basic();
        b = sq.size(); bd = dt.size(); d0 = dbl;
        pulse0(t0);
        n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise got=%b exp=1", busy0); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cyc == t0 + 29) begin
                n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL basic_busy_before_done got=%b exp=1", busy0); end
            end
            if (cyc == t0 + 30) begin
                n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done got=%b exp=0", busy0); end
            end
        end
        n_cmp++;
        if (sq.size() - b !== 10) begin n_err++; $display("FAIL basic_count got=%0d exp=10", sq.size() - b); end
        else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++; if (sq[b+i] !== mem0[i]) begin n_err++; $display("FAIL basic_byte%0d got=%h exp=%h", i, sq[b+i], mem0[i]); end
            end
            n_cmp++; if (st[b] !== t0 + 2) begin n_err++; $display("FAIL basic_first_strobe got=%0d exp=%0d", st[b] - t0, 2); end
            for (int i = 1; i < 10; i++) begin
                n_cmp++; if (st[b+i] - st[b+i-1] !== 3) begin n_err++; $display("FAIL basic_spacing%0d got=%0d exp=3", i, st[b+i] - st[b+i-1]); end
            end
        end
        n_cmp++;
        if (dt.size() - bd !== 1) begin n_err++; $display("FAIL basic_done_count got=%0d exp=1", dt.size() - bd); end
        else begin
            n_cmp++; if (dt[bd] !== t0 + 30) begin n_err++; $display("FAIL basic_done_time got=%0d exp=30", dt[bd] - t0); end
        end
        n_cmp++; if (dbl !== d0) begin n_err++; $display("FAIL basic_double_strobe got=%0d exp=%0d", dbl, d0); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({addr0, txd0, new0, busy0, done0} !== 15'd0) begin
            n_err++; $display("FAIL reset_outputs got=%h/%h/%b/%b/%b exp=0", addr0, txd0, new0, busy0, done0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if (addr0 !== 4'd0 || busy0 !== 1'b0 || new0 !== 1'b0) begin
                n_err++; $display("FAIL reset_idle cycle%0d addr=%h busy=%b new=%b exp=0", i, addr0, busy0, new0);
            end
        end
    endtask

    task automatic test_stall();
        int t0, b, bd;
        bit got;
        load_random0();
        b = sq.size(); bd = dt.size();
        pulse0(t0);
        for (int c = 0; c < 10; c++) begin
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk);
                if (new0) got = 1'b1;
            end
            n_cmp++;
            if (!got) begin n_err++; $display("FAIL stall_timeout char%0d got=none exp=strobe", c); break; end
            @(negedge clk);
            tx_busy0 = 1'b1;
            repeat (10) @(negedge clk);
            if (c < 9) begin
                n_cmp++; if (txd0 !== mem0[c+1]) begin n_err++; $display("FAIL stall_hold%0d got=%h exp=%h", c, txd0, mem0[c+1]); end
            end
            tx_busy0 = 1'b0;
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (sq.size() - b !== 10) begin n_err++; $display("FAIL stall_count got=%0d exp=10", sq.size() - b); end
        else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++; if (sq[b+i] !== mem0[i]) begin n_err++; $display("FAIL stall_byte%0d got=%h exp=%h", i, sq[b+i], mem0[i]); end
            end
            for (int i = 1; i < 10; i++) begin
                n_cmp++; if (st[b+i] - st[b+i-1] !== 12) begin n_err++; $display("FAIL stall_spacing%0d got=%0d exp=12", i, st[b+i] - st[b+i-1]); end
            end
        end
        n_cmp++; if (dt.size() - bd !== 1) begin n_err++; $display("FAIL stall_done_count got=%0d exp=1", dt.size() - bd); end
    endtask

    task automatic test_start_during_busy();
        int t0, b, bd;
        load_random0();
        b = sq.size(); bd = dt.size();
        @(negedge clk);
        start0 = 1'b1;
        t0 = cyc + 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start0 = (cyc == t0 + 5 || cyc == t0 + 12 || cyc == t0 + 30);
        end
        start0 = 1'b0;
        n_cmp++; if (sq.size() - b !== 10) begin n_err++; $display("FAIL busy_start_count got=%0d exp=10", sq.size() - b); end
        n_cmp++;
        if (dt.size() - bd !== 1) begin n_err++; $display("FAIL busy_start_done_count got=%0d exp=1", dt.size() - bd); end
        else begin
            n_cmp++; if (dt[bd] !== t0 + 30) begin n_err++; $display("FAIL busy_start_done_time got=%0d exp=30", dt[bd] - t0); end
        end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL busy_start_idle got=%b exp=0", busy0); end
    endtask

    task automatic test_reset_mid();
        int t0, b, bd;
        load_basic();
        b = sq.size(); bd = dt.size();
        pulse0(t0);
        while (cyc < t0 + 13) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (new0 !== 1'b0 || addr0 !== 4'd0 || busy0 !== 1'b0) begin
            n_err++; $display("FAIL midrst_outputs new=%b addr=%h busy=%b exp=0", new0, addr0, busy0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++; if (sq.size() - b !== 4) begin n_err++; $display("FAIL midrst_strobes got=%0d exp=4", sq.size() - b); end
        n_cmp++; if (dt.size() - bd !== 0) begin n_err++; $display("FAIL midrst_done got=%0d exp=0", dt.size() - bd); end
        b = sq.size();
        pulse0(t0);
        repeat (40) @(negedge clk);
        n_cmp++;
        if (sq.size() - b !== 10) begin n_err++; $display("FAIL midrst_restart_count got=%0d exp=10", sq.size() - b); end
        else begin
            n_cmp++; if (sq[b] !== 8'h31) begin n_err++; $display("FAIL midrst_first_byte got=%h exp=31", sq[b]); end
            n_cmp++; if (sq[b+9] !== 8'h0D) begin n_err++; $display("FAIL midrst_last_byte got=%h exp=0d", sq[b+9]); end
        end
    endtask

    task automatic test_len1();
        int t0, ns, nd, ts, td;
        logic [7:0] by;
        ns = 0; nd = 0; ts = -1; td = -1; by = 8'h00;
        mem1[0] = 8'($urandom_range(1, 255));
        for (int i = 1; i < 16; i++) mem1[i] = ~mem1[0];
        @(negedge clk);
        start1 = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (new1) begin ns++; ts = cyc; by = txd1; end
            if (done1) begin nd++; td = cyc; end
        end
        n_cmp++; if (ns !== 1) begin n_err++; $display("FAIL len1_count got=%0d exp=1", ns); end
        n_cmp++; if (ts !== t0 + 4) begin n_err++; $display("FAIL len1_strobe_time got=%0d exp=4", ts - t0); end
        n_cmp++; if (by !== mem1[0]) begin n_err++; $display("FAIL len1_byte got=%h exp=%h", by, mem1[0]); end
        n_cmp++; if (nd !== 1 || td !== t0 + 5) begin n_err++; $display("FAIL len1_done count=%0d time=%0d exp=1/5", nd, td - t0); end
        n_cmp++; if (busy1 !== 1'b0 || addr1 !== 4'd0) begin n_err++; $display("FAIL len1_idle busy=%b addr=%h exp=0/0", busy1, addr1); end
    endtask

    task automatic test_len16();
        int t0, nd, td;
        logic [7:0] q [$];
        logic [3:0] amax;
        nd = 0; td = -1; amax = 4'd0;
        for (int i = 0; i < 16; i++) mem2[i] = 8'($urandom);
        @(negedge clk);
        start2 = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (addr2 > amax) amax = addr2;
            if (new2) q.push_back(txd2);
            if (done2) begin nd++; td = cyc; end
        end
        n_cmp++;
        if (q.size() !== 16) begin n_err++; $display("FAIL len16_count got=%0d exp=16", q.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++; if (q[i] !== mem2[i]) begin n_err++; $display("FAIL len16_byte%0d got=%h exp=%h", i, q[i], mem2[i]); end
            end
        end
        n_cmp++; if (amax !== 4'd15) begin n_err++; $display("FAIL len16_max_addr got=%0d exp=15", amax); end
        n_cmp++; if (nd !== 1 || td !== t0 + 64) begin n_err++; $display("FAIL len16_done count=%0d time=%0d exp=1/64", nd, td - t0); end
        n_cmp++; if (addr2 !== 4'd0 || busy2 !== 1'b0) begin n_err++; $display("FAIL len16_idle addr=%h busy=%b exp=0/0", addr2, busy2); end
    endtask

    initial begin
        rst = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        tx_busy0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 8'h00; mem1[i] = 8'h00; mem2[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_basic();
        test_reset();
        test_stall();
        test_start_during_busy();
        test_reset_mid();
        test_len1();
        test_len16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
